// File: rtl/serial_mag_cmp_pkg.sv
// Shared types and sizing helpers for the bit-serial magnitude comparator.
package serial_mag_cmp_pkg;

   localparam int unsigned DEF_WIDTH = 8;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      CMP  = 2'd1,
      DONE = 2'd2
   } state_e;

   // One-hot comparison result as held in the flag register.
   typedef struct packed {
      logic gt;
      logic eq;
      logic lt;
   } cmp_res_t;

   // Bit-counter width; $clog2(1) is 0, so clamp to a single bit.
   function automatic int unsigned cnt_width(input int unsigned width);
      return (width <= 1) ? 1 : $clog2(width);
   endfunction

endpackage

// File: rtl/serial_mag_cmp_if.sv
// Start/ready request channel plus done-qualified one-hot result.
interface serial_mag_cmp_if
   import serial_mag_cmp_pkg::*;
#(
   parameter int unsigned WIDTH = DEF_WIDTH
) ();

   logic             start;
   logic [WIDTH-1:0] a;
   logic [WIDTH-1:0] b;
   logic             ready;
   logic             done;
   logic             a_great_b;
   logic             a_equal_b;
   logic             a_less_b;

   modport master (
      output start, a, b,
      input  ready, done, a_great_b, a_equal_b, a_less_b
   );

   modport slave (
      input  start, a, b,
      output ready, done, a_great_b, a_equal_b, a_less_b
   );

endinterface

// File: rtl/serial_mag_cmp_ctrl_cmp_1bit.sv
// Combinational single-bit comparator with one-hot gt/eq/lt outputs.
module cmp_1bit (
   input  logic a,
   input  logic b,
   output logic gt,
   output logic eq,
   output logic lt
);

   assign gt = a & ~b;
   assign lt = ~a & b;
   assign eq = ~(a ^ b);

endmodule

// File: rtl/serial_mag_cmp_ctrl.sv
// Bit-serial unsigned magnitude comparator: MSB first, one bit per clock,
// early exit on the first differing bit.
module serial_mag_cmp_ctrl
   import serial_mag_cmp_pkg::*;
#(
   parameter int unsigned WIDTH = DEF_WIDTH
) (
   input logic             clk,
   input logic             rst_n,
   serial_mag_cmp_if.slave bus
);

   localparam int unsigned CW = cnt_width(WIDTH);

   state_e           state, state_nx;
   logic [WIDTH-1:0] sa, sa_nx;
   logic [WIDTH-1:0] sb, sb_nx;
   logic [CW-1:0]    cnt, cnt_nx;
   cmp_res_t         res, res_nx;
   logic             ready_q;
   logic             done_q;
   logic             c_gt, c_eq, c_lt;

   cmp_1bit u_cmp (
      .a  (sa[WIDTH-1]),
      .b  (sb[WIDTH-1]),
      .gt (c_gt),
      .eq (c_eq),
      .lt (c_lt)
   );

   // State and datapath registers; ready/done are decoded from the next state
   // so they are flops aligned with the state they describe.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state   <= IDLE;
         sa      <= '0;
         sb      <= '0;
         cnt     <= '0;
         res     <= '0;
         ready_q <= 1'b1;
         done_q  <= 1'b0;
      end else begin
         state   <= state_nx;
         sa      <= sa_nx;
         sb      <= sb_nx;
         cnt     <= cnt_nx;
         res     <= res_nx;
         ready_q <= (state_nx == IDLE);
         done_q  <= (state_nx == DONE);
      end
   end

   // Next-state and datapath update.
   always_comb begin
      state_nx = state;
      sa_nx    = sa;
      sb_nx    = sb;
      cnt_nx   = cnt;
      res_nx   = res;
      case (state)
         IDLE: begin
            if (bus.start) begin
               sa_nx    = bus.a;
               sb_nx    = bus.b;
               cnt_nx   = CW'(WIDTH - 1);
               state_nx = CMP;
            end
         end
         CMP: begin
            // A differing bit or the last bit both decide; the comparator is
            // already one-hot, so its outputs are the result in either case.
            if (!c_eq || (cnt == '0)) begin
               res_nx.gt = c_gt;
               res_nx.eq = c_eq;
               res_nx.lt = c_lt;
               state_nx  = DONE;
            end else begin
               sa_nx  = sa << 1;
               sb_nx  = sb << 1;
               cnt_nx = cnt - CW'(1);
            end
         end
         DONE: begin
            state_nx = IDLE;
         end
         default: begin
            state_nx = IDLE;
         end
      endcase
   end

   assign bus.ready     = ready_q;
   assign bus.done      = done_q;
   assign bus.a_great_b = res.gt;
   assign bus.a_equal_b = res.eq;
   assign bus.a_less_b  = res.lt;

endmodule

// File: tb/tb_serial_mag_cmp_ctrl.sv
// Directed bench for serial_mag_cmp_ctrl at WIDTH=8 with hand-computed results.
module tb_serial_mag_cmp_ctrl;

   logic clk = 1'b0;
   logic rst_n;
   int   errors = 0;
   int   checks = 0;
   logic [2:0] last_flags;

   always #5 clk = ~clk;

   serial_mag_cmp_if #(.WIDTH(8)) bus ();

   serial_mag_cmp_ctrl #(.WIDTH(8)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus.slave)
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   function automatic logic [2:0] flags();
      return {bus.a_great_b, bus.a_equal_b, bus.a_less_b};
   endfunction

   // Accept one operation in the current cycle and measure accept-to-done latency.
   task automatic run_op(input logic [7:0] av, input logic [7:0] bv, input int lat,
                         input logic [2:0] exp_f, input bit noise, input string tag);
      int n;
      check({tag, "_ready_pre"}, 32'(bus.ready), 32'd1);
      bus.start = 1'b1;
      bus.a     = av;
      bus.b     = bv;
      tick();
      n = 1;
      if (noise) begin
         bus.a = 8'h00;
         bus.b = 8'hFF;
      end else begin
         bus.start = 1'b0;
         bus.a     = ~av;
         bus.b     = ~bv;
      end
      check({tag, "_ready_busy"}, 32'(bus.ready), 32'd0);
      check({tag, "_flags_hold"}, 32'(flags()), 32'(last_flags));
      while (bus.done !== 1'b1 && n < 20) begin
         tick();
         n++;
      end
      bus.start = 1'b0;
      check({tag, "_latency"}, 32'(n), 32'(lat));
      check({tag, "_flags"}, 32'(flags()), 32'(exp_f));
      last_flags = exp_f;
      tick();
      check({tag, "_done_drop"}, 32'(bus.done), 32'd0);
      check({tag, "_ready_back"}, 32'(bus.ready), 32'd1);
   endtask

   initial begin
      int pulses;
      rst_n     = 1'b0;
      bus.start = 1'b0;
      bus.a     = '0;
      bus.b     = '0;
      last_flags = 3'b000;

      // Reset held for two cycles
      tick();
      tick();
      rst_n = 1'b1;
      check("rst_ready", 32'(bus.ready), 32'd1);
      check("rst_done", 32'(bus.done), 32'd0);
      check("rst_flags", 32'(flags()), 32'd0);
      tick();

      // Equal operands take the full WIDTH+1 cycles
      run_op(8'hA5, 8'hA5, 9, 3'b010, 1'b0, "eq_a5");
      tick();

      // MSB decides, then back-to-back with a bit-0 decision
      run_op(8'h80, 8'h7F, 2, 3'b100, 1'b0, "gt_msb");
      run_op(8'h12, 8'h13, 9, 3'b001, 1'b0, "lt_lsb_b2b");
      tick();

      // Starts during CMP and DONE must be ignored
      run_op(8'h40, 8'h00, 3, 3'b100, 1'b1, "gt_noise");
      pulses = 0;
      for (int i = 0; i < 4; i++) begin
         tick();
         if (bus.done === 1'b1) pulses++;
      end
      check("noise_extra_done", 32'(pulses), 32'd0);
      check("noise_flags_kept", 32'(flags()), 32'b100);

      // Reset mid-compare aborts without a done pulse
      bus.start = 1'b1;
      bus.a     = 8'hF0;
      bus.b     = 8'hF1;
      tick();
      bus.start = 1'b0;
      pulses = 0;
      for (int i = 0; i < 3; i++) begin
         if (bus.done === 1'b1) pulses++;
         tick();
      end
      rst_n = 1'b0;
      tick();
      rst_n = 1'b1;
      check("abort_ready", 32'(bus.ready), 32'd1);
      check("abort_flags", 32'(flags()), 32'd0);
      for (int i = 0; i < 8; i++) begin
         if (bus.done === 1'b1) pulses++;
         tick();
      end
      check("abort_no_done", 32'(pulses), 32'd0);
      last_flags = 3'b000;

      run_op(8'h01, 8'h02, 8, 3'b001, 1'b0, "lt_after_rst");

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
